fft_r2_stage_feeder: RTL
========================

Name: fft_r2_stage_feeder

Overview:
- Radix-2 DIF stage input feeder; sits directly upstream of `butterfly`.
- Accepts a natural-order complex sample stream of N_POINTS-sample blocks and stores the first half of each block.
- On the second half it issues pairs (x[k], x[k+N/2]) with twiddle W^k, valid-aligned to the butterfly's a/b/twiddle/i_valid inputs.
- Twiddles are fetched from an external registered ROM through an address port.

Parameters:
- WIDTH, 16, signed sample width (real and imag each).
- TW_WIDTH, 10, signed twiddle width; 1.0 = 2^(TW_WIDTH-2).
- N_POINTS, 16, block length; power of two, >= 4.

Ports:
- clk  in  1  stage clock.
- rst  in  1  reset.
- i_valid  in  1  input sample strobe; no backpressure.
- i_real  in  WIDTH  input sample, real.
- i_imag  in  WIDTH  input sample, imag.
- tw_addr  out  log2(N_POINTS)-1  twiddle ROM address k.
- tw_rd_real  in  TW_WIDTH  ROM data, real; valid one cycle after tw_addr.
- tw_rd_imag  in  TW_WIDTH  ROM data, imag; valid one cycle after tw_addr.
- a_real  out  WIDTH  x[k], real.
- a_imag  out  WIDTH  x[k], imag.
- b_real  out  WIDTH  x[k+N/2], real.
- b_imag  out  WIDTH  x[k+N/2], imag.
- twiddle_real  out  TW_WIDTH  W^k, real.
- twiddle_imag  out  TW_WIDTH  W^k, imag.
- o_valid  out  1  pair valid; drives butterfly i_valid.
- o_last  out  1  high with o_valid on pair k = N/2-1.

Behaviour:
- Clock and reset: single clock `clk`. `rst` is synchronous, active-high.
- Reset values: all outputs 0, including tw_addr, o_valid and o_last. Counter = 0, state = FILL, pipeline valids cleared. Buffer RAM is not cleared.
- Block counter `cnt`, width log2(N_POINTS)-1: increments on each i_valid and wraps N/2-1 -> 0. The wrap toggles state FILL <-> PAIR.
- FILL state: each i_valid writes {i_real, i_imag} to buf[cnt]. No output.
- PAIR state, cycle C with i_valid:
  - The buffer is read at address cnt (synchronous read).
  - At the edge ending C: register b = input sample, a = buf[cnt], tw_addr <= cnt, stage-1 valid <= 1, stage-1 last <= (cnt == N/2-1).
  - At the edge ending C+1: register a/b outputs, twiddle_* <= tw_rd_*, o_valid <= stage-1 valid, o_last <= stage-1 last.
  - Fixed latency is 2 cycles from accepted sample to o_valid.
- Outputs hold their last values when o_valid = 0. o_valid is a 1-cycle pulse per pair.
- tw_addr holds its value between updates.
- Gapped input (i_valid low for any number of cycles): the counter and state freeze; the output spacing mirrors the input spacing.
- Back-to-back blocks: the FILL write of the next block (buf[0] at C+1) never collides with the final PAIR read (buf[N/2-1] at C). No stall and no bubble is needed.
- Arithmetic: none. Data passes unchanged, signed, at full width.
- Reset mid-block: partial block discarded. The next i_valid after reset is treated as x[0] of a new block. In-flight pairs are dropped (o_valid stays 0).

Optional Feature:
- Macro: FEEDER_BLOCK_SYNC_EN.
- Defined:
  - Adds input `i_sop` (1 bit) and output `o_err` (1 bit, reset 0).
  - i_valid & i_sop forces the sample to be x[0]: cnt <= 1, state FILL, sample written to buf[0].
  - If this occurs while not at a block boundary (cnt != 0 or state == PAIR), o_err pulses high for 1 cycle, registered on the same edge.
  - Pairs already in the pipeline still complete.
- Undefined: no `i_sop` or `o_err` ports; blocks are delimited only by counting.

Test Plan:
- N_POINTS=8, 8 back-to-back samples with i_real = 0..7, i_imag = 0..7 -> 4 o_valid pulses with (a, b) = (0,4), (1,5), (2,6), (3,7) on both real and imag. tw_addr = 0, 1, 2, 3. o_last on the 4th pulse only. First o_valid 2 cycles after sample 4.
- ROM model returns (256, 0) for k=0 and (181, -181) for k=1 -> twiddle outputs match per pair; no off-by-one against tw_addr.
- Same block with random 0-4 cycle i_valid gaps -> identical pair sequence, each o_valid exactly 2 cycles after its b sample.
- Two consecutive blocks with no gap -> 8 pulses; the second block's pairs come from the second block's data (e.g. values 10..17 give (10,14)...). No corruption at the FILL/PAIR boundary.
- rst asserted for 1 cycle after sample 5 of a block -> no outputs from that block. The next 8 samples produce a correct full block.
- With FEEDER_BLOCK_SYNC_EN: i_sop on sample 3 -> o_err = 1 for one cycle. The sample becomes x[0]. The following 7 samples plus that one yield 4 correct pairs.

Source files
------------

// File: rtl/fft_r2_stage_feeder_if.sv
// rtl/fft_r2_stage_feeder_if.sv - sample-in / butterfly-pair-out bus of the radix-2 DIF stage feeder
interface fft_r2_stage_feeder_if #(
    parameter int WIDTH    = 16,
    parameter int TW_WIDTH = 10
);
    logic                       i_valid;
    logic signed [WIDTH-1:0]    i_real;
    logic signed [WIDTH-1:0]    i_imag;
    logic signed [WIDTH-1:0]    a_real;
    logic signed [WIDTH-1:0]    a_imag;
    logic signed [WIDTH-1:0]    b_real;
    logic signed [WIDTH-1:0]    b_imag;
    logic signed [TW_WIDTH-1:0] twiddle_real;
    logic signed [TW_WIDTH-1:0] twiddle_imag;
    logic                       o_valid;
    logic                       o_last;

    modport master (
        output i_valid, i_real, i_imag,
        input  a_real, a_imag, b_real, b_imag, twiddle_real, twiddle_imag, o_valid, o_last
    );

    modport slave (
        input  i_valid, i_real, i_imag,
        output a_real, a_imag, b_real, b_imag, twiddle_real, twiddle_imag, o_valid, o_last
    );
endinterface

// File: rtl/fft_r2_stage_feeder.sv
// rtl/fft_r2_stage_feeder.sv - radix-2 DIF stage feeder pairing x[k], x[k+N/2] with W^k
// Optional block sync (i_sop/o_err) enabled by defining FEEDER_BLOCK_SYNC_EN.
module fft_r2_stage_feeder #(
    parameter int WIDTH    = 16,
    parameter int TW_WIDTH = 10,
    parameter int N_POINTS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef FEEDER_BLOCK_SYNC_EN
    input  logic                          i_sop,
    output logic                          o_err,
`endif
    fft_r2_stage_feeder_if.slave          bus,
    output logic [$clog2(N_POINTS)-2:0]   tw_addr,
    input  logic signed [TW_WIDTH-1:0]    tw_rd_real,
    input  logic signed [TW_WIDTH-1:0]    tw_rd_imag
);
    localparam int CW   = $clog2(N_POINTS) - 1;
    localparam int HALF = N_POINTS / 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

    typedef enum logic {FILL, PAIR} state_t;

    logic [2*WIDTH-1:0]    buf_mem [HALF];
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         tw_addr_q, tw_addr_d;
    logic [CW-1:0]         wr_addr;
    logic                  wr_en, pair_go;
    logic [2*WIDTH-1:0]    s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [2*WIDTH-1:0]    a_q, a_d, b_q, b_d;
    logic [2*TW_WIDTH-1:0] tw_q, tw_d;
    logic                  s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic                  o_valid_q, o_valid_d, o_last_q, o_last_d;
`ifdef FEEDER_BLOCK_SYNC_EN
    logic                  err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = cnt_q;
        pair_go = 1'b0;
        if (bus.i_valid) begin
            cnt_d   = cnt_q + CW'(1);
            wr_en   = (state_q == FILL);
            pair_go = (state_q == PAIR);
            if (cnt_q == CNT_LAST) begin
                state_d = (state_q == FILL) ? PAIR : FILL;
            end
        end
`ifdef FEEDER_BLOCK_SYNC_EN
        err_d = 1'b0;
        // A start-of-packet sample restarts the block as x[0]; flag it if it cut a block short.
        if (bus.i_valid && i_sop) begin
            cnt_d   = CW'(1);
            state_d = FILL;
            wr_en   = 1'b1;
            wr_addr = '0;
            pair_go = 1'b0;
            err_d   = (cnt_q != '0) || (state_q == PAIR);
        end
`endif
        // Stage 1: buffer read and twiddle address launch; ROM data lines up one cycle later.
        s1_a_d     = pair_go ? buf_mem[cnt_q] : s1_a_q;
        s1_b_d     = pair_go ? {bus.i_real, bus.i_imag} : s1_b_q;
        tw_addr_d  = pair_go ? cnt_q : tw_addr_q;
        s1_valid_d = pair_go;
        s1_last_d  = pair_go && (cnt_q == CNT_LAST);

        a_d       = s1_valid_q ? s1_a_q : a_q;
        b_d       = s1_valid_q ? s1_b_q : b_q;
        tw_d      = s1_valid_q ? {tw_rd_real, tw_rd_imag} : tw_q;
        o_valid_d = s1_valid_q;
        o_last_d  = s1_valid_q && s1_last_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_addr] <= {bus.i_real, bus.i_imag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            tw_addr_q  <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            tw_q       <= '0;
            o_valid_q  <= 1'b0;
            o_last_q   <= 1'b0;
`ifdef FEEDER_BLOCK_SYNC_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tw_addr_q  <= tw_addr_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            a_q        <= a_d;
            b_q        <= b_d;
            tw_q       <= tw_d;
            o_valid_q  <= o_valid_d;
            o_last_q   <= o_last_d;
`ifdef FEEDER_BLOCK_SYNC_EN
            err_q      <= err_d;
`endif
        end
    end

    assign tw_addr          = tw_addr_q;
    assign bus.a_real       = a_q[2*WIDTH-1:WIDTH];
    assign bus.a_imag       = a_q[WIDTH-1:0];
    assign bus.b_real       = b_q[2*WIDTH-1:WIDTH];
    assign bus.b_imag       = b_q[WIDTH-1:0];
    assign bus.twiddle_real = tw_q[2*TW_WIDTH-1:TW_WIDTH];
    assign bus.twiddle_imag = tw_q[TW_WIDTH-1:0];
    assign bus.o_valid      = o_valid_q;
    assign bus.o_last       = o_last_q;
`ifdef FEEDER_BLOCK_SYNC_EN
    assign o_err            = err_q;
`endif
endmodule
